// File: rtl/lane_pkg.sv
// Shared types and lane arithmetic for the lane increment-sum pipeline.
// Functions work on a wide word so one code path serves any WIDTH <= MAX_W.
package lane_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_LANES = 16;
    localparam int MAX_W     = 30;

    typedef logic [DEF_WIDTH-1:0] lane_t;
    typedef logic [MAX_W+1:0]     word_t;

    typedef struct packed {
        logic  ovf;
        word_t res;
    } op_t;

    function automatic word_t lane_mask(input int unsigned w);
        return (word_t'(1) << w) - word_t'(1);
    endfunction

    function automatic word_t inc(input word_t x, input int unsigned w);
        return (x + word_t'(1)) & lane_mask(w);
    endfunction

    // Two spare bits above w hold the sum carry, so overflow is exact.
    function automatic op_t lane_op(
        input word_t       acc,
        input word_t       a,
        input word_t       b,
        input logic        mode,
        input logic        sat,
        input int unsigned w
    );
        op_t   r;
        word_t s;
        s     = inc(a, w) + inc(b, w) + (mode ? acc : '0);
        r.ovf = (s >> w) != '0;
        r.res = (sat && r.ovf) ? lane_mask(w) : (s & lane_mask(w));
        return r;
    endfunction

endpackage

// File: rtl/lane_incsum_stage.sv
// One pipeline register slot: holds a beat until the next slot takes it.
// Loads whenever it is empty or its current beat leaves this cycle.
module lane_incsum_stage
    import lane_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          out_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    output logic [PW-1:0] out_data
);

    logic          v_q;
    logic          v_d;
    logic [PW-1:0] d_q;
    logic [PW-1:0] d_d;
    logic          open;

    assign open = !v_q || out_ready;

    always_comb begin
        v_d = open ? in_valid : v_q;
        d_d = (open && in_valid) ? in_data : d_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign out_valid = v_q;
    assign out_data  = d_q;

endmodule

// File: rtl/lane_incsum_pipe.sv
// Multi-lane inc(a)+inc(b) with per-lane accumulators and saturation,
// behind a bubble-collapsing valid/ready pipeline of STAGES slots.
module lane_incsum_pipe
    import lane_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LANES  = DEF_LANES,
    parameter int STAGES = 2,
    parameter int SAT    = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   mode,
    input  logic                   acc_clr,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_ovf
);

    localparam int DW = LANES * WIDTH;
    localparam int PW = DW + LANES;

    logic                        accept;
    logic [LANES-1:0][WIDTH-1:0] acc_q;
    logic [LANES-1:0][WIDTH-1:0] acc_d;
    logic [DW-1:0]               res;
    logic [LANES-1:0]            ovf;

    assign accept = in_valid && in_ready;

    // Clear wins first, so a beat accepted with acc_clr sees acc = 0.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        op_t              op;
        logic [WIDTH-1:0] acc_use;
        logic             unused_hi;

        assign acc_use = acc_clr ? '0 : acc_q[i];
        assign op      = lane_op(word_t'(acc_use),
                                 word_t'(in_a[i*WIDTH +: WIDTH]),
                                 word_t'(in_b[i*WIDTH +: WIDTH]),
                                 mode, SAT != 0, WIDTH);

        assign res[i*WIDTH +: WIDTH] = op.res[WIDTH-1:0];
        assign ovf[i]    = op.ovf;
        assign acc_d[i]  = (accept && mode) ? op.res[WIDTH-1:0] : acc_use;
        assign unused_hi = ^op.res[$bits(word_t)-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] stg_rdy;
    logic              room;

    // A slot may release its beat if any later slot is empty or out drains.
    always_comb begin
        room    = out_ready;
        stg_rdy = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            stg_rdy[k] = room;
            room       = room || !v[k];
        end
    end

    assign in_ready = room;

    logic [PW-1:0] pd [STAGES+1];

    assign pd[0] = {ovf, res};

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic vin;

        if (k == 0) begin : g_head
            assign vin = in_valid;
        end else begin : g_body
            assign vin = v[k-1];
        end

        lane_incsum_stage #(
            .PW(PW)
        ) u_stg (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (vin),
            .out_ready(stg_rdy[k]),
            .in_data  (pd[k]),
            .out_valid(v[k]),
            .out_data (pd[k+1])
        );
    end

    assign out_valid          = v[STAGES-1];
    assign {out_ovf, out_data} = pd[STAGES];

endmodule

// File: doc/lane_incsum_pipe.md
Name: lane_incsum_pipe

Overview:
Multi-lane, pipelined successor to the single-cycle per-lane increment-sum block. Each lane computes inc(a)+inc(b), where inc(x)=x+1 mod 2^WIDTH. Lanes can run in plain sum mode or per-lane accumulate mode, with optional saturation. It sits between lane-packed producer and consumer buses and uses a valid/ready handshake on both sides, with full backpressure support.

Parameters:
WIDTH, 4, lane data width in bits (>=2)
LANES, 16, number of independent lanes
STAGES, 2, pipeline depth 1..4; accept-to-output latency in cycles
SAT, 0, 0 = wrap mod 2^WIDTH, 1 = saturate to all-ones on overflow

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
mode  in  1  sampled with beat: 0 = sum, 1 = accumulate
acc_clr  in  1  synchronous clear of all lane accumulators
in_a  in  LANES*WIDTH  lane i at [i*WIDTH +: WIDTH]
in_b  in  LANES*WIDTH  lane i at [i*WIDTH +: WIDTH]
out_valid  out  1  output beat valid
out_ready  in  1  consumer accepts the beat
out_data  out  LANES*WIDTH  lane results, same packing as the inputs
out_ovf  out  LANES  per-lane overflow flag for the current output beat

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_ovf=0.
  - All stage valids=0 and all accumulators=0.
  - in_ready=1 on the first cycle after deassertion.
- Accept: a beat is accepted when in_valid && in_ready. Transfer: a beat leaves when out_valid && out_ready.
- Lane arithmetic, evaluated at accept:
  - ia=inc(a), ib=inc(b), each WIDTH bits, wrapping (F+1=0 at WIDTH=4; this wrap is not an overflow).
  - Sum mode: s = ia+ib, computed at WIDTH+1 bits.
  - Accumulate mode: s = acc+ia+ib, computed at WIDTH+2 bits.
  - ovf = (s >= 2^WIDTH).
  - Result: SAT=0 gives s mod 2^WIDTH; SAT=1 gives all-ones when ovf, else s.
- Accumulator:
  - In accumulate mode the lane accumulator is updated at accept to the result value (wrapped or saturated).
  - Sum-mode beats leave the accumulators untouched.
- acc_clr:
  - Clears all accumulators at the clock edge.
  - If asserted in the same cycle as an accepted accumulate beat, that beat uses acc=0 and the accumulator takes the beat's result (clear first, then accumulate).
  - acc_clr does not affect beats already in the pipeline.
- Pipeline:
  - STAGES registered stages, each holding {valid, data, ovf}. Out ports are driven from the last stage.
  - Stage k loads from stage k-1 when stage k is empty or is draining this cycle.
  - in_ready = !v[0] || stage 0 draining. The ready chain is combinational from out_ready (bubble-collapsing).
  - Throughput is 1 beat/cycle with out_ready held high.
  - Latency: a beat accepted at edge t shows out_valid at edge t+STAGES-1 (STAGES cycles in flight, counting the accept cycle).
- Backpressure:
  - With out_ready=0, data holds stable and out_valid stays high until transfer.
  - in_ready falls once all STAGES slots are full.
  - No beat is lost, duplicated or reordered.
  - Full pipeline with out_ready=1 and in_valid=1: accept and transfer happen in the same cycle.
- Empty pipeline: out_valid=0, out_data holds its last value (don't-care for the checker).
- Reset mid-operation: in-flight beats and accumulators are discarded immediately.

Decomposition:
- Package lane_pkg holds:
  - the default WIDTH and LANES localparams;
  - typedef lane_t of WIDTH bits;
  - function automatic inc(lane_t) returning lane_t;
  - function automatic lane_op(acc, a, b, mode, sat) returning {ovf, result}.
- One sub-module, lane_incsum_stage: a single pipeline register stage with valid/ready and parametrised payload width. It is instantiated STAGES times by a generate loop.
- Lane arithmetic uses a generate-for over LANES.

Test Plan:
All scenarios use WIDTH=4, LANES=2, STAGES=2, SAT=0 unless noted.
- Sum: lane0 a=3,b=5; lane1 a=F,b=F; mode=0 -> lane0=A, ovf=0; lane1=0, ovf=0 (inc wraps). out_valid is high 1 edge after the accept edge.
- Overflow: a=7, b=8 -> 8+9=17 -> out=1, ovf=1. With SAT=1 -> out=F, ovf=1.
- Accumulate: acc_clr pulse, then beats (1,1), (2,2), (F,E) in mode=1 -> 4, A, A+0+F=19 -> 9 with ovf=1; the accumulator then holds 9. A following sum-mode beat (0,0) -> 2, and the accumulator stays 9.
- acc_clr with an accumulate beat (3,3) when acc=9 -> out=8; the next accumulate beat (0,0) -> A.
- Backpressure: hold out_ready=0 and push 4 back-to-back beats -> in_ready=0 after 2 accepts; raise out_ready -> all 4 emerge in order with no gaps while in_valid is held.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight and acc=5 -> out_valid=0 asynchronously. After release, accumulate beat (0,0) -> 2 (acc restarted from 0).
